// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
//   A hit completes in the same cycle: the read is combinational and the write
//   is committed at the clock edge. A miss raises a stall, writes back a dirty
//   victim if there is one, fills the line, and then the held access looks the
//   line up again and hits.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cpu_read_i, cpu_write_i       MemRead / MemWrite (never both high)
//   cpu_addr_i, cpu_data_i        byte address, store data
//   cpu_data_o                    load data (read-hit cycle only, else 0)
//   cpu_stall_o                   combinational pipeline stall
//   mem_req_o, mem_write_o        line request; 1 = write-back, 0 = fill
//   mem_addr_o, mem_data_o        line-aligned address, write-back data
//   mem_data_i, mem_ack_i         fill data, one-cycle acknowledge
module dcache_controller #(
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_read_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t               r_state, w_next;
  logic [SETS-1:0]      r_valid;
  logic [SETS-1:0]      r_dirty;
  logic [TAG_W-1:0]     r_tag  [SETS];
  logic [LINE_BITS-1:0] r_data [SETS];

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [2:0]           w_wsel;
  logic [7:0]           w_bitoff;
  logic                 w_access;
  logic                 w_hit;
  logic                 w_wr_hit;
  logic                 w_fill;

  assign w_idx    = cpu_addr_i[4+IDX_W:5];
  assign w_tag    = cpu_addr_i[31:5+IDX_W];
  assign w_wsel   = cpu_addr_i[4:2];
  assign w_bitoff = {w_wsel, 5'b0};
  assign w_access = cpu_read_i | cpu_write_i;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_hit = (r_state == S_IDLE) && cpu_write_i && w_hit;
  assign w_fill   = (r_state == S_ALLOCATE) && mem_ack_i;

  // Outputs are forced to their idle values while reset is asserted so that
  // an interrupted transaction drops its request immediately.
  always_comb begin
    w_next      = r_state;
    cpu_data_o  = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_hit) begin
              if (cpu_read_i) cpu_data_o = r_data[w_idx][w_bitoff +: 32];
            end else begin
              cpu_stall_o = 1'b1;
              w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_write_o = 1'b1;
          mem_addr_o  = {r_tag[w_idx], w_idx, 5'b0};
          mem_data_o  = r_data[w_idx];
          if (mem_ack_i) w_next = S_ALLOCATE;
        end
        S_ALLOCATE: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {w_tag, w_idx, 5'b0};
          if (mem_ack_i) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone decides their use.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_wr_hit) r_data[w_idx][w_bitoff +: 32] <= cpu_data_i;
      if (w_fill) begin
        r_data[w_idx] <= mem_data_i;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios followed by random accesses,
// checked against a line-level cache model and a backing-memory model.
module tb_dcache_controller;

  localparam int SETS = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd, wr;
  logic [31:0]  addr, wdata, rdata;
  logic         stall, req, mwr;
  logic [31:0]  maddr;
  logic [255:0] mdo, mdi;
  logic         ack;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  // Model: per set, the resident line address and contents; plus backing memory.
  bit           m_valid [SETS];
  bit           m_dirty [SETS];
  logic [31:0]  m_laddr [SETS];
  logic [255:0] m_line  [SETS];
  logic [255:0] backing [int unsigned];

  dcache_controller #(.SETS(SETS), .LINE_BITS(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_read_i(rd), .cpu_write_i(wr), .cpu_addr_i(addr), .cpu_data_i(wdata),
    .cpu_data_o(rdata), .cpu_stall_o(stall),
    .mem_req_o(req), .mem_write_o(mwr), .mem_addr_o(maddr), .mem_data_o(mdo),
    .mem_data_i(mdi), .mem_ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    if (!backing.exists(la)) backing[la] = rand_line();
    return backing[la];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  // One CPU access. k1/k2 = ack cycle for write-back / fill (0 = random).
  task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        input int unsigned k1_in, input int unsigned k2_in);
    logic [31:0]  la   = {a[31:5], 5'b0};
    int unsigned  idx  = (a >> 5) % SETS;
    int unsigned  w    = a[4:2];
    bit           hit  = m_valid[idx] && (m_laddr[idx] == la);
    bit           wb   = !hit && m_valid[idx] && m_dirty[idx];
    int unsigned  k1   = (k1_in != 0) ? k1_in : $urandom_range(1, 4);
    int unsigned  k2   = (k2_in != 0) ? k2_in : $urandom_range(1, 4);
    int unsigned  exp_stalls = hit ? 0 : 1 + (wb ? k1 : 0) + k2;
    int unsigned  stalls = 0;
    logic [255:0] fill;
    rd = !is_wr; wr = is_wr; addr = a; wdata = d; ack = 1'b0;
    if (!hit) begin
      @(negedge clk);
      stalls += stall;
      check_eq("miss_idle_req", req, 1'b0);
      @(posedge clk); #1;
      if (wb) begin
        for (int c = 1; c <= int'(k1); c++) begin
          @(negedge clk);
          stalls += stall;
          check_eq("wb_req", req, 1'b1);
          check_eq("wb_write", mwr, 1'b1);
          check_eq("wb_addr", maddr, m_laddr[idx]);
          check_eq("wb_data", mdo, m_line[idx]);
          ack = (c == int'(k1));
          @(posedge clk); #1;
          ack = 1'b0;
        end
        backing[m_laddr[idx]] = m_line[idx];
      end
      fill = mem_line(la);
      for (int c = 1; c <= int'(k2); c++) begin
        @(negedge clk);
        stalls += stall;
        check_eq("fill_req", req, 1'b1);
        check_eq("fill_write", mwr, 1'b0);
        check_eq("fill_addr", maddr, la);
        if (c == 1) check_eq("fill_mdo_zero", mdo, '0);
        if (c == int'(k2)) begin
          mdi = fill;
          ack = 1'b1;
        end
        @(posedge clk); #1;
        ack = 1'b0;
        mdi = rand_line();
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_laddr[idx] = la;
      m_line[idx]  = fill;
      check_eq("stall_cycles", stalls, exp_stalls);
    end
    @(negedge clk);
    check_eq("hit_stall", stall, 1'b0);
    check_eq("hit_req", req, 1'b0);
    check_eq("hit_rdata", rdata, is_wr ? 32'h0 : m_line[idx][w*32 +: 32]);
    @(posedge clk); #1;
    if (is_wr) begin
      m_line[idx][w*32 +: 32] = d;
      m_dirty[idx] = 1'b1;
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check_eq({tag, "_req"}, req, 1'b0);
    check_eq({tag, "_stall"}, stall, 1'b0);
    check_eq({tag, "_rdata"}, rdata, 32'h0);
    check_eq({tag, "_mwr"}, mwr, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  ra;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; ack = 1'b0; mdi = '0;
    model_reset();
    idle_check("in_reset");
    rst = 1'b0;
    idle_check("post_reset");

    // Clean read miss at 0x40, word 0 = DEADBEEF, ack in 3rd request cycle.
    l = rand_line();
    l[31:0] = 32'hDEADBEEF;
    backing[32'h40] = l;
    access(1'b0, 32'h0000_0040, '0, 0, 3);
    // Write hit, read back, then dirty eviction through index 2.
    access(1'b1, 32'h0000_0044, 32'h1234_5678, 0, 0);
    access(1'b0, 32'h0000_0044, '0, 0, 0);
    access(1'b0, 32'h0000_0240, '0, 2, 2);
    check_eq("evict_word1", backing[32'h40][63:32], 32'h1234_5678);
    // Write miss, then read the written word and neighbours.
    access(1'b1, 32'h0000_1008, 32'hA5A5_A5A5, 0, 0);
    access(1'b0, 32'h0000_1008, '0, 0, 0);
    access(1'b0, 32'h0000_1000, '0, 0, 0);
    access(1'b0, 32'h0000_101C, '0, 0, 0);

    // Ack held high with no access.
    ack = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("stray_ack");
    ack = 1'b0;
    access(1'b0, 32'h0000_1008, '0, 0, 0);

    // Reset during the second allocate cycle of a clean miss to 0x2060.
    rd = 1'b1; addr = 32'h0000_2060;
    @(negedge clk);
    check_eq("rst_miss_stall", stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_alloc1_req", req, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_alloc2_req", req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd = 1'b0;
    model_reset();
    idle_check("after_abort");
    access(1'b0, 32'h0000_2060, '0, 0, 0);
    access(1'b0, 32'h0000_1008, '0, 0, 0);

    // Random traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      access(1'($urandom_range(0, 1)), ra, $urandom, 0, 0);
      if ($urandom_range(0, 7) == 0) idle_check("rand_idle");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
